// File: rtl/regfile_mp.sv
// Multi-port integer register file with load-miss busy scoreboard.
// Two write ports (WB0 pipeline writeback, WB1 late refill), NRP combinational
// read ports, x0 hardwired to zero.
// Optional feature: define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRP   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wb0_en,
    input  logic [AW-1:0]       wb0_addr,
    input  logic [XLEN-1:0]     wb0_data,
    input  logic                wb1_en,
    input  logic [AW-1:0]       wb1_addr,
    input  logic [XLEN-1:0]     wb1_data,
    input  logic                sb_set_en,
    input  logic [AW-1:0]       sb_set_addr,
    output logic [AW:0]         pending_cnt,
    output logic                err_waw
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [AW-1:0]    ra;

    // Busy scoreboard next state: a new miss overrides a same-cycle refill clear
    always_comb begin
        busy_nxt = busy;
        if (wb1_en) begin
            busy_nxt[wb1_addr] = 1'b0;
        end
        if (sb_set_en && (sb_set_addr != '0)) begin
            busy_nxt[sb_set_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Population count of the next busy vector, so pending_cnt tracks busy edge for edge
    always_comb begin
        cnt_nxt = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
        end
    end

    // Scoreboard, pending count and sticky WAW error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= '0;
            pending_cnt <= '0;
            err_waw     <= 1'b0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
            if (wb0_en && (wb0_addr != '0) && busy[wb0_addr]) begin
                err_waw <= 1'b1;
            end
        end
    end

    // Register storage; wb0 is applied last so it wins an address collision with wb1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (wb1_en && (wb1_addr != '0)) begin
                regs[wb1_addr] <= wb1_data;
            end
            if (wb0_en && (wb0_addr != '0)) begin
                regs[wb0_addr] <= wb0_data;
            end
        end
    end

    // Combinational read ports
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int unsigned i = 0; i < NRP; i++) begin
            ra = rd_addr[i*AW +: AW];
            rd_data[i*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
            rd_busy[i] = busy[ra];
`ifdef RF_BYPASS_EN
            if (ra != '0) begin
                if (wb0_en && (wb0_addr == ra)) begin
                    rd_data[i*XLEN +: XLEN] = wb0_data;
                end else if (wb1_en && (wb1_addr == ra)) begin
                    rd_data[i*XLEN +: XLEN] = wb1_data;
                end
                if (wb1_en && (wb1_addr == ra) && !(sb_set_en && (sb_set_addr == ra))) begin
                    rd_busy[i] = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic, compared against an array-based architectural model.
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRP   = 2;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NRP*AW-1:0]   rd_addr = '0;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wb0_en = 1'b0;
    logic [AW-1:0]       wb0_addr = '0;
    logic [XLEN-1:0]     wb0_data = '0;
    logic                wb1_en = 1'b0;
    logic [AW-1:0]       wb1_addr = '0;
    logic [XLEN-1:0]     wb1_data = '0;
    logic                sb_set_en = 1'b0;
    logic [AW-1:0]       sb_set_addr = '0;
    logic [AW:0]         pending_cnt;
    logic                err_waw;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .pending_cnt(pending_cnt), .err_waw(err_waw)
    );

    always #5 clk = ~clk;

    // Architectural reference state
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_bsy [NREGS];
    bit              m_err;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r] = '0;
            m_bsy[r] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int r = 1; r < NREGS; r++) c += int'(m_bsy[r]);
        return c;
    endfunction

    // Value a read port must show right now, given the current write-port inputs
    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (wb0_en && int'(wb0_addr) == a) return wb0_data;
        if (wb1_en && int'(wb1_addr) == a) return wb1_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (wb1_en && int'(wb1_addr) == a && !(sb_set_en && int'(sb_set_addr) == a)) return 1'b0;
`endif
        return m_bsy[a];
    endfunction

    // Architectural effect of one clock edge
    task automatic model_edge();
        if (wb0_en && wb0_addr != 0 && m_bsy[wb0_addr]) m_err = 1'b1;
        if (wb1_en && wb1_addr != 0) m_mem[wb1_addr] = wb1_data;
        if (wb0_en && wb0_addr != 0) m_mem[wb0_addr] = wb0_data;
        if (wb1_en) m_bsy[wb1_addr] = 1'b0;
        if (sb_set_en && sb_set_addr != 0) m_bsy[sb_set_addr] = 1'b1;
    endtask

    task automatic check_reads(input string tag);
        for (int i = 0; i < NRP; i++) begin
            int a;
            a = int'(rd_addr[i*AW +: AW]);
            chk($sformatf("%s rd_data[%0d] x%0d", tag, i, a), rd_data[i*XLEN +: XLEN], exp_data(a));
            chk($sformatf("%s rd_busy[%0d] x%0d", tag, i, a), 32'(rd_busy[i]), 32'(exp_busy(a)));
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " pending_cnt"}, 32'(pending_cnt), 32'(model_cnt()));
        chk({tag, " err_waw"}, 32'(err_waw), 32'(m_err));
    endtask

    task automatic idle();
        wb0_en = 1'b0; wb1_en = 1'b0; sb_set_en = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0*AW +: AW] = AW'(a0);
        rd_addr[1*AW +: AW] = AW'(a1);
    endtask

    // Check reads with current inputs, clock once, update model, check registered state
    task automatic tick(input string tag);
        #1;
        check_reads({tag, " pre"});
        @(posedge clk);
        model_edge();
        #1;
        idle();
        check_state({tag, " post"});
    endtask

    initial begin
        model_reset();
        set_rd(5, 7);
        #12;
        check_reads("reset");
        check_state("reset");
        chk("reset literal cnt", 32'(pending_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Write x5 and try to write x0
        wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
        tick("wr_x5");
        set_rd(5, 5);
        #1;
        chk("x5 port0", rd_data[31:0], 32'hDEADBEEF);
        chk("x5 port1", rd_data[63:32], 32'hDEADBEEF);
        wb0_en = 1'b1; wb0_addr = 5'd0; wb0_data = 32'h1234;
        tick("wr_x0");
        set_rd(0, 5);
        #1;
        chk("x0 reads zero", rd_data[31:0], 32'h0);

        // Collision on x7 while x7 busy
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        tick("set_x7");
        chk("cnt after set x7", 32'(pending_cnt), 32'd1);
        set_rd(7, 7);
        wb0_en = 1'b1; wb0_addr = 5'd7; wb0_data = 32'hAAAA0000;
        wb1_en = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h5555FFFF;
        tick("collide_x7");
        #1;
        chk("x7 wb0 wins", rd_data[31:0], 32'hAAAA0000);
        chk("x7 busy cleared", 32'(rd_busy[0]), 32'd0);
        chk("cnt after collide", 32'(pending_cnt), 32'd0);
        chk("collide raises waw", 32'(err_waw), 32'd1);

        // Re-setting x3 does not double count; set beats clear on x4
        sb_set_en = 1'b1; sb_set_addr = 5'd3; tick("set_x3");
        sb_set_en = 1'b1; sb_set_addr = 5'd4; tick("set_x4");
        sb_set_en = 1'b1; sb_set_addr = 5'd3; tick("reset_x3");
        chk("cnt two busy", 32'(pending_cnt), 32'd2);
        set_rd(4, 3);
        sb_set_en = 1'b1; sb_set_addr = 5'd4;
        wb1_en = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h44;
        tick("set_clr_x4");
        #1;
        chk("x4 stays busy", 32'(rd_busy[0]), 32'd1);
        chk("cnt still two", 32'(pending_cnt), 32'd2);

        // wb1 to a non-busy register: no error effect beyond what is already sticky
        wb1_en = 1'b1; wb1_addr = 5'd20; wb1_data = 32'h2020;
        tick("wb1_nonbusy");

        // WAW on busy x9
        sb_set_en = 1'b1; sb_set_addr = 5'd9; tick("set_x9");
        set_rd(9, 9);
        wb0_en = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h1;
        tick("waw_x9");
        #1;
        chk("waw err", 32'(err_waw), 32'd1);
        chk("x9 data", rd_data[31:0], 32'h1);
        chk("x9 still busy", 32'(rd_busy[0]), 32'd1);
        wb0_en = 1'b1; wb0_addr = 5'd10; wb0_data = 32'h10;
        tick("traffic");
        chk("waw sticky", 32'(err_waw), 32'd1);

        // Same-cycle refill of busy x12 observed on the read port
        sb_set_en = 1'b1; sb_set_addr = 5'd12; tick("set_x12");
        set_rd(12, 12);
        wb1_en = 1'b1; wb1_addr = 5'd12; wb1_data = 32'hCAFE;
        #1;
`ifdef RF_BYPASS_EN
        chk("x12 bypass data", rd_data[31:0], 32'hCAFE);
        chk("x12 bypass busy", 32'(rd_busy[0]), 32'd0);
`else
        chk("x12 old data", rd_data[31:0], 32'h0);
        chk("x12 old busy", 32'(rd_busy[0]), 32'd1);
`endif
        tick("wb1_x12");
        #1;
        chk("x12 new data", rd_data[31:0], 32'hCAFE);
        chk("x12 new busy", 32'(rd_busy[0]), 32'd0);

        // Random traffic, biased toward low registers for collisions
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NRP; i++)
                rd_addr[i*AW +: AW] = AW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            wb0_en      = ($urandom_range(0, 3) == 0);
            wb0_addr    = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            wb0_data    = $urandom;
            wb1_en      = ($urandom_range(0, 2) == 0);
            wb1_addr    = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            wb1_data    = $urandom;
            sb_set_en   = ($urandom_range(0, 2) == 0);
            sb_set_addr = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            tick($sformatf("rand%0d", n));
        end

        // Make sure some state is non-zero, then reset asynchronously mid-cycle
        wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
        sb_set_en = 1'b1; sb_set_addr = 5'd6;
        tick("pre_reset");
        set_rd(5, 6);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async rst x5", rd_data[31:0], 32'h0);
        chk("async rst busy x6", 32'(rd_busy[1]), 32'd0);
        chk("async rst cnt", 32'(pending_cnt), 32'd0);
        chk("async rst err", 32'(err_waw), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        wb0_en = 1'b1; wb0_addr = 5'd6; wb0_data = 32'h66;
        tick("post_reset");
        check_reads("post_reset rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
